dff_share_arbiter: RTL and testbench
====================================

// Module: dff_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register among NUM_REQ requesters.
//  Grants exclusive write ownership via req/grant handshake; muxes owner's data into the register; drives q/qbar.
//  Sits between client blocks and the shared state register; flags illegal (non-owner) writes.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  WIDTH     8   register width in bits
//  MAX_HOLD  16  max consecutive grant cycles before preemption (used only with DFF_ARB_TIMEOUT_EN)
//  PTR_W     localparam = clog2(NUM_REQ), round-robin pointer width
// PORTS
//  clk      in   1              system clock, rising edge
//  rstn     in   1              asynchronous active-low reset
//  req      in   NUM_REQ        per-requester ownership request, level, held until done
//  wr       in   NUM_REQ        per-requester write strobe
//  d_in     in   NUM_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH]
//  grant    out  NUM_REQ        registered one-hot ownership grant
//  busy     out  1              1 while state == GRANT
//  q        out  WIDTH          shared register value
//  qbar     out  WIDTH          ~q, registered with q
//  wr_err   out  1              one-cycle pulse: wr asserted by a non-granted requester
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, grant=0, busy=0, q=0, qbar=all-ones, wr_err=0, rr_ptr=0, hold_cnt=0.
//  FSM states: IDLE, GRANT, GAP.
//   IDLE: if |req, pick first set req[i] scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ); next edge grant[i]=1, ->GRANT.
//         Latency req->grant = 1 cycle. No req: stay IDLE.
//   GRANT: owner keeps grant while req[owner]=1. req[owner]=0 sampled -> grant=0, rr_ptr=owner+1 (wrap), ->GAP.
//   GAP: exactly one dead cycle, grant=0, no arbitration; ->IDLE. Release-to-next-grant = 2 cycles.
//  Write: at edge, if grant[i]&wr[i] then q<=d_in[i], qbar<=~d_in[i]; else q/qbar hold.
//   Write with grant high and req dropping same cycle IS accepted (grant still high that cycle).
//  wr_err: registered; =1 the cycle after any wr[j]=1 with grant[j]=0 (includes IDLE/GAP). Illegal write ignored.
//  Non-owner req changes during GRANT have no effect; pending reqs wait.
//  rr_ptr wraps NUM_REQ-1 -> 0. Single requester re-requesting after release is re-granted (pointer skips absent reqs).
//  rstn asserted mid-GRANT: immediate return to reset values; q is lost (cleared).
// CONFIGURATION
//  DFF_ARB_TIMEOUT_EN defined:
//   hold_cnt counts GRANT cycles from 0. When hold_cnt==MAX_HOLD-1 and any other req pending,
//   owner is preempted: grant=0, rr_ptr=owner+1, ->GAP, same as release. No other req pending: hold_cnt saturates,
//   grant kept. Preempted owner's write in its final granted cycle is accepted.
//  Not defined: no hold_cnt logic; grant held until owner drops req (unbounded).
// STRUCTURE
//  Shared package dff_arb_pkg: state encodings (IDLE=2'b00, GRANT=2'b01, GAP=2'b10), clog2 function.
//  Sub-module rr_pick: combinational, inputs req+rr_ptr, outputs one-hot pick + valid; instantiated once.
//  Top holds FSM, rr_ptr, owner index, hold_cnt, data mux, q/qbar register, wr_err register.
// TESTING
//  1 Reset: rstn=0 mid-run -> grant=0, q=8'h00, qbar=8'hFF, busy=0 asynchronously, before next edge.
//  2 Single grant+write: req=4'b0100 -> grant=4'b0100 next cycle; wr[2]=1,d_in[2]=8'hA5 -> q=8'hA5,qbar=8'h5A.
//  3 Round robin: req=4'b1111 held; each owner drops req 3 cycles after grant then re-raises -> grant order 0,1,2,3,0
//    with 2 zero-grant cycles between owners.
//  4 Illegal write: grant=4'b0001, wr=4'b0010,d_in[1]=8'h33 -> q unchanged, wr_err=1 one cycle.
//  5 Release+write same cycle: owner 3 drops req with wr[3]=1,d=8'hC3 -> q=8'hC3, state GAP, rr_ptr=0.
//  6 Timeout (DFF_ARB_TIMEOUT_EN, MAX_HOLD=16): req[0] held, req[1] raised -> grant[0] drops after exactly 16 cycles,
//    grant[1] 2 cycles later; without macro grant[0] stays for 100 cycles.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and
// an elaboration-time ceil(log2) helper.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ; returns a one-hot pick and a valid flag.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register with q/qbar.
// Optional hold-time preemption is enabled by defining DFF_ARB_TIMEOUT_EN.
module dff_share_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       wr,
  input  logic [NUM_REQ*WIDTH-1:0] d_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic                     wr_err
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_param_check
    $error("dff_share_arbiter: NUM_REQ must be 2..8 and MAX_HOLD >= 1");
  end

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [WIDTH-1:0]    qbar_q, qbar_d;
  logic                wr_err_q, wr_err_d;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    owner_nxt;
  logic                preempt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .valid  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Counter is zero on the first GRANT cycle and saturates at MAX_HOLD-1
  // so a late-arriving competitor preempts the owner immediately.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != ST_GRANT) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  assign preempt = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_LAST) &&
                   (|(req & ~grant_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q] || preempt) begin
          grant_d  = '0;
          rr_ptr_d = owner_nxt;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the current grant holder can load the register; since grant is
  // one-hot, owner_q selects the data lane. A releasing owner still writes.
  always_comb begin
    q_d      = q_q;
    qbar_d   = qbar_q;
    wr_err_d = |(wr & ~grant_q);
    if (|(wr & grant_q)) begin
      q_d    = d_in[int'(owner_q)*WIDTH +: WIDTH];
      qbar_d = ~d_in[int'(owner_q)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      q_q      <= '0;
      qbar_q   <= '1;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      q_q      <= q_d;
      qbar_q   <= qbar_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = (state_q == ST_GRANT);
  assign q      = q_q;
  assign qbar   = qbar_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter (NUM_REQ=4, WIDTH=8, MAX_HOLD=16).
module tb_dff_share_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [3:0]  wr;
  logic [31:0] d_in;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        wr_err;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  int         exp_owner[$];

  dff_share_arbiter #(
    .NUM_REQ  (4),
    .WIDTH    (8),
    .MAX_HOLD (16)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .wr     (wr),
    .d_in   (d_in),
    .grant  (grant),
    .busy   (busy),
    .q      (q),
    .qbar   (qbar),
    .wr_err (wr_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    wr   = '0;
    d_in = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    do_reset();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL reset_ctrl: grant=%b busy=%b required 0000/0", grant, busy); else passes++;
    checks++; if (q !== 8'h00 || qbar !== 8'hFF || wr_err !== 1'b0) $display("FAIL reset_data: q=%h qbar=%h wr_err=%b required 00/FF/0", q, qbar, wr_err); else passes++;
    req = 4'b0001;
    @(negedge clk);
    wr = 4'b0001; d_in[7:0] = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (q !== e) $display("FAIL pre_reset_write: q=%h required %h", q, e); else passes++;
    wr = 4'b0010;
    @(negedge clk);
    wr = 4'b0000;
    #2 rstn = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || wr_err !== 1'b0) $display("FAIL async_reset_ctrl: grant=%b busy=%b wr_err=%b required 0000/0/0", grant, busy, wr_err); else passes++;
    checks++; if (q !== 8'h00 || qbar !== 8'hFF) $display("FAIL async_reset_data: q=%h qbar=%h required 00/FF", q, qbar); else passes++;
    req = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [7:0] e;
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0100 || busy !== 1'b1) $display("FAIL single_grant: grant=%b busy=%b required 0100/1", grant, busy); else passes++;
    wr = 4'b0100; d_in[23:16] = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr = 4'b0000;
    e = exp_q.pop_front();
    checks++; if (q !== e || qbar !== ~e) $display("FAIL single_write: q=%h qbar=%h required %h/%h", q, qbar, e, ~e); else passes++;
    checks++; if (wr_err !== 1'b0) $display("FAIL single_no_err: wr_err=%b required 0", wr_err); else passes++;
    req = 4'b0000;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL single_release: grant=%b required 0000", grant); else passes++;
  endtask

  task automatic test_round_robin();
    logic [3:0] prev;
    int held;
    int gap;
    int seen;
    int eo;
    do_reset();
    exp_owner = {0, 1, 2, 3, 0};
    req  = 4'b1111;
    prev = '0;
    held = 0;
    gap  = 0;
    seen = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (grant !== 4'b0000) begin
        if (prev === 4'b0000) begin
          eo = exp_owner.pop_front();
          checks++; if (grant !== 4'(1 << eo)) $display("FAIL rr_order: grant=%b required owner %0d", grant, eo); else passes++;
          if (seen > 0) begin
            checks++; if (gap !== 2) $display("FAIL rr_gap: zero-grant cycles=%0d required 2", gap); else passes++;
          end
          seen++;
          held = 1;
          gap  = 0;
        end else begin
          held++;
        end
        if (held == 3) req = req & ~grant;
      end else begin
        gap++;
        req = 4'b1111;
      end
      prev = grant;
      if (exp_owner.size() == 0 && held == 3) break;
    end
    checks++; if (exp_owner.size() != 0) $display("FAIL rr_timeout: %0d grants still pending, required 0", exp_owner.size()); else passes++;
    exp_owner.delete();
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_illegal_write();
    logic [7:0] e;
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    wr = 4'b0001; d_in[7:0] = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (q !== e) $display("FAIL owner_write: q=%h required %h", q, e); else passes++;
    wr = 4'b0010; d_in[15:8] = 8'h33; exp_q.push_back(8'h11);
    @(negedge clk);
    wr = 4'b0000;
    e = exp_q.pop_front();
    checks++; if (q !== e || qbar !== ~e) $display("FAIL illegal_ignored: q=%h qbar=%h required %h/%h", q, qbar, e, ~e); else passes++;
    checks++; if (wr_err !== 1'b1) $display("FAIL illegal_flag: wr_err=%b required 1", wr_err); else passes++;
    @(negedge clk);
    checks++; if (wr_err !== 1'b0) $display("FAIL illegal_pulse: wr_err=%b required 0", wr_err); else passes++;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    wr = 4'b0100; d_in[23:16] = 8'hEE;
    @(negedge clk);
    wr = 4'b0000;
    checks++; if (wr_err !== 1'b1 || q !== 8'h11) $display("FAIL idle_illegal: wr_err=%b q=%h required 1/11", wr_err, q); else passes++;
  endtask

  task automatic test_release_write();
    logic [7:0] e;
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) $display("FAIL rel_grant: grant=%b required 1000", grant); else passes++;
    req = 4'b0000; wr = 4'b1000; d_in[31:24] = 8'hC3; exp_q.push_back(8'hC3);
    @(negedge clk);
    wr = 4'b0000;
    e = exp_q.pop_front();
    checks++; if (q !== e || qbar !== ~e) $display("FAIL rel_write: q=%h qbar=%h required %h/%h", q, qbar, e, ~e); else passes++;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL rel_gap: grant=%b busy=%b required 0000/0", grant, busy); else passes++;
    req = 4'b1001;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL rel_dead: grant=%b required 0000", grant); else passes++;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) $display("FAIL rel_wrap: grant=%b required 0001", grant); else passes++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) $display("FAIL b2b_dead: grant=%b required 0000", grant); else passes++;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) $display("FAIL b2b_regrant: grant=%b required 0100", grant); else passes++;
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int own_cnt;
    int zero_cnt;
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0011;
    own_cnt = 0;
    zero_cnt = 0;
`ifdef DFF_ARB_TIMEOUT_EN
    for (int cyc = 0; cyc < 200 && grant === 4'b0001; cyc++) begin
      own_cnt++;
      @(negedge clk);
    end
    checks++; if (own_cnt !== 16) $display("FAIL timeout_hold: owner cycles=%0d required 16", own_cnt); else passes++;
    for (int cyc = 0; cyc < 20 && grant === 4'b0000; cyc++) begin
      zero_cnt++;
      @(negedge clk);
    end
    checks++; if (zero_cnt !== 2 || grant !== 4'b0010) $display("FAIL timeout_next: gap=%0d grant=%b required 2/0010", zero_cnt, grant); else passes++;
`else
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (grant === 4'b0001) own_cnt++;
      @(negedge clk);
    end
    checks++; if (own_cnt !== 100) $display("FAIL no_timeout_hold: owner cycles=%0d required 100", own_cnt); else passes++;
    checks++; if (zero_cnt !== 0 || busy !== 1'b1) $display("FAIL no_timeout_busy: busy=%b required 1", busy); else passes++;
`endif
    req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    wr   = '0;
    d_in = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_illegal_write();
    test_release_write();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
